// File: rtl/rom_pkg.sv
// Shared types and sizing helpers for the ROM streaming readers.
package rom_pkg;

    // Reader control states; exposed on the debug state port of the top level.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Output buffer depth: one slot per in-flight read plus two for the
    // registered output and one word of backpressure slack.
    function automatic int fifo_depth(input int read_lat);
        return read_lat + 2;
    endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO with a registered output stage (no fall-through).
// Capacity is DEPTH words in storage plus the output register; the reader's
// credit logic keeps total occupancy within DEPTH. count_o covers both.
module rom_rd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] mem_cnt_q;
    logic             out_vld_q;
    logic [WIDTH-1:0] out_data_q;

    logic pop, out_free, mem_empty, load_mem, bypass, push_mem;

    // Output register refills from storage first, else directly from the write port.
    always_comb begin
        pop       = out_vld_q && rd_ready_i;
        out_free  = !out_vld_q || pop;
        mem_empty = (mem_cnt_q == '0);
        load_mem  = out_free && !mem_empty;
        bypass    = out_free && mem_empty && wr_en_i;
        push_mem  = wr_en_i && !bypass;
    end

    // Storage, pointers and output register update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (out_free) begin
                if (!mem_empty) begin
                    out_data_q <= mem_q[rd_ptr_q];
                    out_vld_q  <= 1'b1;
                end else if (wr_en_i) begin
                    out_data_q <= wr_data_i;
                    out_vld_q  <= 1'b1;
                end else begin
                    out_vld_q  <= 1'b0;
                end
            end
            if (push_mem) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (load_mem) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            mem_cnt_q <= mem_cnt_q + CNT_W'(push_mem) - CNT_W'(load_mem);
        end
    end

    assign rd_valid_o = out_vld_q;
    assign rd_data_o  = out_data_q;
    assign count_o    = mem_cnt_q + CNT_W'(out_vld_q);

endmodule

// File: rtl/rom_stream_reader.sv
// Streams a programmable address window of a fixed-latency synchronous ROM
// onto a valid/ready interface, tagging the final word of each pass.
// Handshake: a word transfers on a rising edge where m_valid && m_ready;
// m_data/m_last hold while m_valid=1 and m_ready=0, and m_valid never
// depends combinationally on m_ready.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int LEN_W    = ADDR_W + 1
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              loop_en,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addra,
    input  logic [DATA_W-1:0] rom_douta,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output rd_state_e         state_o
);

    localparam int DEPTH = fifo_depth(READ_LAT);
    localparam int CNT_W = $clog2(DEPTH + 2);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q, base_q;
    logic [LEN_W-1:0]  len_q, issued_q;
    logic              loop_q, done_q;
    logic [READ_LAT-1:0] tag_vld_q, tag_last_q;

    logic [CNT_W-1:0] fifo_cnt, inflight;
    logic [CNT_W:0]   occ;
    logic             credit_ok, issue, last_issue, xfer, drain_empty;
    logic [DATA_W:0]  fifo_out;

    // Credit: a read is issued only if a buffer slot is reserved for its data.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + CNT_W'(tag_vld_q[i]);
        occ         = {1'b0, fifo_cnt} + {1'b0, inflight};
        credit_ok   = occ < (CNT_W + 1)'(DEPTH);
        issue       = (state_q == RUN) && credit_ok;
        last_issue  = issue && (issued_q == len_q - LEN_W'(1));
        xfer        = m_valid && m_ready;
        // Counts the final transfer of this edge so done lands the next cycle.
        drain_empty = (inflight == '0) &&
                      ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && xfer));
    end

    // Control FSM: window capture, address/issue counting, pass looping, done.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= length;
                        loop_q   <= loop_en;
                        addr_q   <= base_addr;
                        issued_q <= '0;
                        if (length == '0) done_q  <= 1'b1;
                        else              state_q <= RUN;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        if (loop_q && !stop) begin
                            addr_q   <= base_q;
                            issued_q <= '0;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= DRAIN;
                        end
                    end else if (issue) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        issued_q <= issued_q + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipeline mirrors the ROM latency so returning data is captured with its last flag.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= last_issue;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    rom_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i      (clka),
        .rst_ni     (rsta_n),
        .wr_en_i    (tag_vld_q[READ_LAT-1]),
        .wr_data_i  ({tag_last_q[READ_LAT-1], rom_douta}),
        .rd_ready_i (m_ready),
        .rd_valid_o (m_valid),
        .rd_data_o  (fifo_out),
        .count_o    (fifo_cnt)
    );

    assign m_data    = fifo_out[DATA_W-1:0];
    assign m_last    = fifo_out[DATA_W];
    assign rom_ena   = issue;
    assign rom_addra = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: two instances (READ_LAT 1 and 3) share stimulus,
// each with a behavioural ROM (mem[a] = a[7:0]) and its own expected queues.
module tb_rom_stream_reader;
    import rom_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          loop_en = 1'b0;
    logic          stop = 1'b0;
    logic          m_ready = 1'b1;

    logic busy1, done1, ena1, mvalid1, mlast1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] douta1, mdata1;
    rd_state_e state1;
    logic busy3, done3, ena3, mvalid3, mlast3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] douta3, mdata3;
    rd_state_e state3;

    rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .LEN_W(LW)) u1 (
        .clka(clk), .rsta_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .loop_en(loop_en), .stop(stop), .busy(busy1), .done(done1), .rom_ena(ena1),
        .rom_addra(addr1), .rom_douta(douta1), .m_data(mdata1), .m_valid(mvalid1),
        .m_ready(m_ready), .m_last(mlast1), .state_o(state1));

    rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .LEN_W(LW)) u3 (
        .clka(clk), .rsta_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .loop_en(loop_en), .stop(stop), .busy(busy3), .done(done3), .rom_ena(ena3),
        .rom_addra(addr3), .rom_douta(douta3), .m_data(mdata3), .m_valid(mvalid3),
        .m_ready(m_ready), .m_last(mlast3), .state_o(state3));

    // Behavioural ROMs: output register chain of READ_LAT stages.
    logic [DW-1:0] r1_q;
    logic [DW-1:0] r3_q [3];
    always @(posedge clk) begin
        if (ena1) r1_q <= addr1[7:0];
        if (ena3) r3_q[0] <= addr3[7:0];
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign douta1 = r1_q;
    assign douta3 = r3_q[2];

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q1 [$];
    logic [DW:0]   exp_q3 [$];
    logic [AW-1:0] exp_a1 [$];
    logic [AW-1:0] exp_a3 [$];

    task automatic push_words(input logic [AW-1:0] b, input int len, input int passes);
        logic [AW-1:0] a;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                a = b + AW'(i);
                exp_a1.push_back(a);
                exp_a3.push_back(a);
                exp_q1.push_back({(i == len - 1), a[7:0]});
                exp_q3.push_back({(i == len - 1), a[7:0]});
            end
        end
    endtask

    logic          pv1 = 1'b0, pv3 = 1'b0, pr = 1'b0;
    logic [DW:0]   pw1, pw3;
    int            max1 = 0, max3 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ena1) begin
                if (exp_a1.size() == 0) chk("addr1_extra", 32'(ena1), 0);
                else chk("addr1", 32'(addr1), 32'(exp_a1.pop_front()));
            end
            if (ena3) begin
                if (exp_a3.size() == 0) chk("addr3_extra", 32'(ena3), 0);
                else chk("addr3", 32'(addr3), 32'(exp_a3.pop_front()));
            end
            if (mvalid1 && m_ready) begin
                if (exp_q1.size() == 0) chk("data1_extra", 32'(mvalid1), 0);
                else chk("data1", 32'({mlast1, mdata1}), 32'(exp_q1.pop_front()));
            end
            if (mvalid3 && m_ready) begin
                if (exp_q3.size() == 0) chk("data3_extra", 32'(mvalid3), 0);
                else chk("data3", 32'({mlast3, mdata3}), 32'(exp_q3.pop_front()));
            end
            if (pv1 && !pr) chk("hold1", 32'({mvalid1, mlast1, mdata1}), 32'({1'b1, pw1}));
            if (pv3 && !pr) chk("hold3", 32'({mvalid3, mlast3, mdata3}), 32'({1'b1, pw3}));
            if (int'(u1.u_fifo.count_o) > max1) max1 = int'(u1.u_fifo.count_o);
            if (int'(u3.u_fifo.count_o) > max3) max3 = int'(u3.u_fifo.count_o);
        end
        pv1 = mvalid1 && rst_n;
        pv3 = mvalid3 && rst_n;
        pw1 = {mlast1, mdata1};
        pw3 = {mlast3, mdata3};
        pr  = m_ready;
    end

    // ---------------- m_ready pattern ----------------
    int rdy_mode = 0;
    int phase = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       m_ready = (phase % 3 == 0);
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
        phase++;
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic lp);
        @(negedge clk);
        base_addr = b;
        length    = l;
        loop_en   = lp;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    int   n, fv1, fv3, dn1, dn3, lt1, lt3;
    logic c1_busy1, c1_ena1, c1_busy3, dn_busy1, dn_busy3;

    // Observes cycles 1.. after the start edge until both instances pulse done.
    task automatic wait_done(input int budget);
        n = 0; fv1 = -1; fv3 = -1; dn1 = -1; dn3 = -1; lt1 = -1; lt3 = -1;
        while ((dn1 < 0 || dn3 < 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                c1_busy1 = busy1; c1_ena1 = ena1; c1_busy3 = busy3;
            end
            if (fv1 < 0 && mvalid1) fv1 = n;
            if (fv3 < 0 && mvalid3) fv3 = n;
            if (mvalid1 && m_ready && mlast1) lt1 = n;
            if (mvalid3 && m_ready && mlast3) lt3 = n;
            if (dn1 < 0 && done1) begin dn1 = n; dn_busy1 = busy1; end
            if (dn3 < 0 && done3) begin dn3 = n; dn_busy3 = busy3; end
        end
        chk("done1_seen", 32'(dn1 >= 0), 1);
        chk("done3_seen", 32'(dn3 >= 0), 1);
    endtask

    task automatic check_done_timing(input string tag);
        chk({tag, "_done1_lat"}, 32'(dn1), 32'(lt1 + 1));
        chk({tag, "_done3_lat"}, 32'(dn3), 32'(lt3 + 1));
        chk({tag, "_busy1_at_done"}, 32'(dn_busy1), 0);
        chk({tag, "_busy3_at_done"}, 32'(dn_busy3), 0);
        chk({tag, "_q1_empty"}, 32'(exp_q1.size()), 0);
        chk({tag, "_q3_empty"}, 32'(exp_q3.size()), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out1"}, 32'({busy1, done1, ena1, mvalid1, mlast1}), 0);
        chk({tag, "_out3"}, 32'({busy3, done3, ena3, mvalid3, mlast3}), 0);
        chk({tag, "_addr1"}, 32'(addr1), 0);
        chk({tag, "_addr3"}, 32'(addr3), 0);
        chk({tag, "_data1"}, 32'(mdata1), 0);
        chk({tag, "_data3"}, 32'(mdata3), 0);
        chk({tag, "_state1"}, 32'(state1), 32'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [AW-1:0] rb;
        int            rl;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic window, full throughput.
        rdy_mode = 0;
        push_words(16'h0010, 4, 1);
        start_op(16'h0010, 17'd4, 1'b0);
        wait_done(200);
        chk("basic_busy1_c1", 32'(c1_busy1), 1);
        chk("basic_busy3_c1", 32'(c1_busy3), 1);
        chk("basic_ena1_c1", 32'(c1_ena1), 1);
        chk("basic_first_valid1", 32'(fv1), 3);
        chk("basic_first_valid3", 32'(fv3), 5);
        chk("basic_last1_cycle", 32'(lt1), 6);
        check_done_timing("basic");

        // Window wrapping past the top of the address space.
        push_words(16'hFFFE, 4, 1);
        start_op(16'hFFFE, 17'd4, 1'b0);
        wait_done(200);
        check_done_timing("wrap");

        // Backpressure 1 on / 2 off, longer window.
        rdy_mode = 1;
        max1 = 0; max3 = 0;
        push_words(16'h0300, 16, 1);
        start_op(16'h0300, 17'd16, 1'b0);
        wait_done(400);
        check_done_timing("toggle");
        chk("toggle_cnt3_max", 32'(max3 <= 5), 1);
        chk("toggle_cnt1_max", 32'(max1 <= 3), 1);

        // Loop mode, stop raised during the second pass.
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        push_words(16'h0020, 3, 2);
        start_op(16'h0020, 17'd3, 1'b1);
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        wait_done(200);
        stop = 1'b0;
        check_done_timing("loop");

        // Zero length: immediate done, no reads.
        start_op(16'h0050, 17'd0, 1'b0);
        wait_done(20);
        chk("len0_done1_cycle", 32'(dn1), 1);
        chk("len0_done3_cycle", 32'(dn3), 1);
        chk("len0_busy1_c1", 32'(c1_busy1), 0);
        chk("len0_ena1_c1", 32'(c1_ena1), 0);
        @(negedge clk);
        chk("len0_done1_pulse", 32'(done1), 0);

        // Start while busy is ignored.
        push_words(16'h0040, 6, 1);
        start_op(16'h0040, 17'd6, 1'b0);
        @(negedge clk);
        base_addr = 16'h0080;
        length    = 17'd2;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        check_done_timing("busy_start");
        repeat (10) @(negedge clk);
        chk("busy_start_idle1", 32'(busy1), 0);
        chk("busy_start_idle3", 32'(busy3), 0);

        // Random backpressure, random window.
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) begin
            rb = AW'($urandom_range(0, 65535));
            rl = $urandom_range(1, 20);
            push_words(rb, rl, 1);
            start_op(rb, LW'(rl), 1'b0);
            wait_done(600);
            check_done_timing("random");
        end

        // Reset mid-stream, then a fresh operation.
        rdy_mode = 1;
        push_words(16'h0100, 16, 1);
        start_op(16'h0100, 17'd16, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q1.delete(); exp_q3.delete(); exp_a1.delete(); exp_a3.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        push_words(16'h0200, 5, 1);
        start_op(16'h0200, 17'd5, 1'b0);
        wait_done(200);
        chk("after_reset_first_valid1", 32'(fv1), 3);
        chk("after_reset_first_valid3", 32'(fv3), 5);
        check_done_timing("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Parametrised synchronous-ROM streaming reader, the successor to our single-port ROM address drivers. It scans a programmable address window of a block-memory ROM (addra/douta/clka style, fixed read latency) and presents the words on a valid/ready stream with a per-pass last flag. It absorbs ROM read latency and downstream backpressure with a small credit-controlled FIFO. Optional loop mode repeats the window until stopped.

## Interface
- ADDR_W, 16, ROM address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 8, ROM/stream data width
- READ_LAT, 1, ROM read latency in clka edges (legal 1..3)
- LEN_W, ADDR_W+1, width of length field (allows full 2^ADDR_W window)

- clka  in  1  single clock, all logic on rising edge
- rsta_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- base_addr  in  ADDR_W  first address of window, latched on accepted start
- length  in  LEN_W  words per pass, latched on accepted start
- loop_en  in  1  latched on accepted start; repeat window when 1
- stop  in  1  level; in loop mode, end after the current pass
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the operation completes
- rom_ena  out  1  ROM read enable
- rom_addra  out  ADDR_W  ROM address
- rom_douta  in  DATA_W  ROM data, valid READ_LAT edges after rom_ena
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  marks the final word of each pass

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches base_addr, length, loop_en. If length=0, pulse done next cycle and stay IDLE; otherwise go to RUN with addr=base, issued=0.
- RUN: issue a read (rom_ena=1, rom_addra=addr) in every cycle where credit>0. credit = FIFO_DEPTH − fifo_count − inflight. FIFO_DEPTH = READ_LAT+2 (localparam).
- Each issue: addr ← addr+1 mod 2^ADDR_W; issued ← issued+1. The issue with issued=length−1 carries the last tag.
- After the last-tagged issue: if loop_en=1 and stop=0 (sampled that cycle), then addr←base, issued←0, stay in RUN. Otherwise go to DRAIN.
- A READ_LAT-deep tag pipeline (valid, last) tracks in-flight reads. Returning rom_douta is written to the FIFO with its last tag on the edge on which it is valid.
- DRAIN: no issues. When inflight=0, the FIFO is empty, and no transfer is pending, pulse done and go to IDLE.
- Stream: a transfer occurs when m_valid&&m_ready. m_data and m_last hold stable while m_valid=1 and m_ready=0.
- start is ignored while busy. stop is ignored when loop_en=0 and when IDLE.
- Credit accounting guarantees no FIFO overflow and no dropped ROM data under any m_ready pattern.

## Timing
- Reset (async assert, sync release): state=IDLE; busy, done, rom_ena, m_valid, m_last = 0; rom_addra = 0; m_data = 0; FIFO, tag pipeline and counters cleared.
- Reset mid-operation: all in-flight data and FIFO contents are discarded; no done pulse.
- start sampled at edge 0: busy=1 and first rom_ena in cycle 1. First m_valid in cycle 2+READ_LAT (registered FIFO output, no fall-through).
- Throughput: one word per cycle sustained while m_ready=1.
- m_ready low: issuing stalls once credit reaches 0, and resumes the cycle after a transfer frees a slot.
- done: asserted the cycle after the final m_last transfer; busy falls in the same cycle.
- Window crossing 2^ADDR_W−1: rom_addra wraps to 0 with no gap.

## Structure
- Package rom_pkg holds the state enum (IDLE/RUN/DRAIN) and the FIFO_DEPTH function of READ_LAT.
- Sub-module rom_rd_fifo: synchronous FIFO, DATA_W+1 wide (data+last), depth parameter, count output, registered output. It instantiates cleanly in other ROM readers.
- Top level holds the FSM, address/issue counters, credit logic and tag pipeline.

## Test plan
- Behavioural ROM with mem[a]=a[7:0], READ_LAT=1, base=0x0010, length=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13, m_last on 0x13, done one cycle later, first m_valid in cycle 3.
- base=0xFFFE, length=4 -> rom_addra FFFE, FFFF, 0000, 0001; data FE, FF, 00, 01.
- READ_LAT=3, length=16, m_ready toggling 1-cycle-on/2-off -> all 16 words in order, no loss or duplication, FIFO count never exceeds 5.
- loop_en=1, length=3, stop raised mid second pass -> exactly 6 words, m_last on words 3 and 6, then done.
- length=0 -> no rom_ena, done pulse in cycle 1, busy stays 0. A start asserted while busy is ignored.
- Assert rsta_n=0 mid-stream -> all outputs 0 immediately. A fresh start after release streams correctly from the new base.
